// File: rtl/heart_beat_pkg.sv
// Shared mode/state types, timing constants and divider helper for the
// multi-channel heartbeat LED block.
package heart_beat_pkg;

  typedef enum logic [2:0] {
    MODE_OFF        = 3'd0,
    MODE_ON         = 3'd1,
    MODE_BLINK_SLOW = 3'd2,
    MODE_BLINK_FAST = 3'd3,
    MODE_CODE       = 3'd4
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_FLASH_ON  = 3'd2,
    ST_FLASH_OFF = 3'd3,
    ST_GAP       = 3'd4
  } code_state_e;

  localparam int PH_W = 4;
  localparam logic [PH_W-1:0] SLOW_HALF   = 4'd8;
  localparam logic [PH_W-1:0] FAST_HALF   = 4'd2;
  localparam logic [PH_W-1:0] FLASH_TICKS = 4'd2;
  localparam logic [PH_W-1:0] GAP_TICKS   = 4'd8;

  function automatic int calc_div(input bit is_debug, input int debug_div,
                                  input int clk_hz, input int tick_hz);
    if (is_debug) begin
      return debug_div;
    end else begin
      return clk_hz / tick_hz;
    end
  endfunction

endpackage

// File: rtl/heart_beat_channel.sv
// One LED channel: latches its mode, counts shared ticks for blink phases
// and runs the blink-code sequencer.
module heart_beat_channel
  import heart_beat_pkg::*;
#(
  parameter int CODE_W = 4
) (
  input  logic              i_clk,
  input  logic              i_s_rst,
  input  logic              i_tick,
  input  logic [2:0]        i_mode,
  input  logic [CODE_W-1:0] i_code,
  output logic              o_led,
  output logic              o_seq_done
);

  logic [2:0]        mode_q, mode_d;
  code_state_e       state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CODE_W-1:0] cnt_q, cnt_d;
  logic              led_q, led_d;
  logic              done_q, done_d;
  logic [PH_W-1:0]   half_s, phase_next_s;
  logic              expire_s;

  // Length of the current phase in ticks and whether this tick ends it.
  always_comb begin
    case (mode_q)
      MODE_BLINK_SLOW: half_s = SLOW_HALF;
      MODE_BLINK_FAST: half_s = FAST_HALF;
      default:         half_s = (state_q == ST_GAP) ? GAP_TICKS : FLASH_TICKS;
    endcase
    expire_s = i_tick && (phase_q == (half_s - PH_W'(1)));
    if (expire_s) begin
      phase_next_s = PH_W'(0);
    end else if (i_tick) begin
      phase_next_s = phase_q + PH_W'(1);
    end else begin
      phase_next_s = phase_q;
    end
  end

  // Next-state logic: a mode change always wins over a coincident tick.
  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    done_d  = 1'b0;
    if (i_mode != mode_q) begin
      mode_d  = i_mode;
      phase_d = PH_W'(0);
      cnt_d   = i_code;
      case (i_mode)
        MODE_ON, MODE_BLINK_SLOW, MODE_BLINK_FAST: begin
          led_d   = 1'b1;
          state_d = ST_IDLE;
        end
        MODE_CODE: begin
          led_d   = 1'b1;
          state_d = ST_LOAD;
        end
        default: begin
          led_d   = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      case (mode_q)
        MODE_ON: led_d = 1'b1;
        MODE_BLINK_SLOW, MODE_BLINK_FAST: begin
          phase_d = phase_next_s;
          led_d   = expire_s ? ~led_q : led_q;
        end
        MODE_CODE: begin
          phase_d = phase_next_s;
          case (state_q)
            ST_LOAD: begin
              // A tick landing on the load cycle still counts toward the first phase.
              phase_d = i_tick ? PH_W'(1) : PH_W'(0);
              if (cnt_q != '0) begin
                state_d = ST_FLASH_ON;
                led_d   = 1'b1;
              end else begin
                state_d = ST_GAP;
                led_d   = 1'b0;
              end
            end
            ST_FLASH_ON: begin
              if (expire_s) begin
                state_d = ST_FLASH_OFF;
                led_d   = 1'b0;
                cnt_d   = cnt_q - CODE_W'(1);
              end else begin
                state_d = ST_FLASH_ON;
              end
            end
            ST_FLASH_OFF: begin
              if (expire_s && (cnt_q != '0)) begin
                state_d = ST_FLASH_ON;
                led_d   = 1'b1;
              end else if (expire_s) begin
                state_d = ST_GAP;
                led_d   = 1'b0;
              end else begin
                state_d = ST_FLASH_OFF;
              end
            end
            ST_GAP: begin
              // The next code is captured here so the LED is already correct during LOAD.
              if (expire_s) begin
                state_d = ST_LOAD;
                cnt_d   = i_code;
                led_d   = (i_code != '0);
                done_d  = 1'b1;
              end else begin
                state_d = ST_GAP;
              end
            end
            default: begin
              state_d = ST_LOAD;
              phase_d = PH_W'(0);
              led_d   = 1'b0;
            end
          endcase
        end
        default: led_d = 1'b0;
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      mode_q  <= MODE_OFF;
      state_q <= ST_IDLE;
      phase_q <= PH_W'(0);
      cnt_q   <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign o_led      = led_q;
  assign o_seq_done = done_q;

endmodule

// File: rtl/heart_beat_multi.sv
// Multi-channel heartbeat: one shared prescaler tick feeding N independent
// LED channels (off / on / slow blink / fast blink / blink-code).
module heart_beat_multi
  import heart_beat_pkg::*;
#(
  parameter int    CHANNELS    = 4,
  parameter int    CLK_FREQ_HZ = 125000000,
  parameter int    TICK_HZ     = 8,
  parameter string IS_DEBUG    = "false",
  parameter int    DEBUG_DIV   = 4,
  parameter int    CODE_W      = 4
) (
  input  logic                       i_clk,
  input  logic                       i_s_rst,
  input  logic [3*CHANNELS-1:0]      i_mode,
  input  logic [CODE_W*CHANNELS-1:0] i_code,
  output logic [CHANNELS-1:0]        o_led,
  output logic                       o_tick,
  output logic [CHANNELS-1:0]        o_seq_done
);

  localparam int DIV = calc_div(IS_DEBUG == "true", DEBUG_DIV, CLK_FREQ_HZ, TICK_HZ);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] PRE_MAX = CW'(DIV - 1);

  logic [CW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;

  // Prescaler wrap produces the registered tick.
  always_comb begin
    if (pre_q == PRE_MAX) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end else begin
      pre_d  = pre_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // Prescaler registers.
  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    heart_beat_channel #(.CODE_W(CODE_W)) u_ch (
      .i_clk      (i_clk),
      .i_s_rst    (i_s_rst),
      .i_tick     (tick_q),
      .i_mode     (i_mode[3*k +: 3]),
      .i_code     (i_code[CODE_W*k +: CODE_W]),
      .o_led      (o_led[k]),
      .o_seq_done (o_seq_done[k])
    );
  end

endmodule

// File: tb/tb_heart_beat_multi.sv
// Bench for heart_beat_multi: directed and random mode/code changes checked
// every cycle against a tick-counting behavioural model.
module tb_heart_beat_multi;

  localparam int CH  = 4;
  localparam int CW  = 4;
  localparam int DIV = 4;

  logic              i_clk = 1'b0;
  logic              i_s_rst;
  logic [3*CH-1:0]   i_mode;
  logic [CW*CH-1:0]  i_code;
  logic [CH-1:0]     o_led;
  logic              o_tick;
  logic [CH-1:0]     o_seq_done;

  int n_vec = 0;
  int n_bad = 0;

  // Model: cycles since reset, plus per channel the mode, ticks elapsed in
  // the current blink run or code sequence, and the code of that sequence.
  int   m_since;
  logic m_tick;
  int   m_mode  [CH];
  int   m_ticks [CH];
  int   m_code  [CH];
  logic m_load  [CH];
  logic m_led   [CH];
  logic m_done  [CH];

  heart_beat_multi #(
    .CHANNELS(CH), .CLK_FREQ_HZ(125000000), .TICK_HZ(8),
    .IS_DEBUG("true"), .DEBUG_DIV(DIV), .CODE_W(CW)
  ) dut (
    .i_clk(i_clk), .i_s_rst(i_s_rst), .i_mode(i_mode), .i_code(i_code),
    .o_led(o_led), .o_tick(o_tick), .o_seq_done(o_seq_done)
  );

  always #5 i_clk = ~i_clk;

  // Code sequence: n flashes of 2 ticks on / 2 ticks off, then 8 ticks dark.
  function automatic logic code_led(int n, int t);
    return (t < 4 * n) && ((t % 4) < 2);
  endfunction

  task automatic model_edge();
    logic t;
    t = m_tick;
    if (i_s_rst) begin
      m_since = 0;
      m_tick  = 1'b0;
    end else begin
      m_since++;
      m_tick = ((m_since % DIV) == 0);
    end
    for (int k = 0; k < CH; k++) begin
      int md;
      int cd;
      int half;
      md = int'(i_mode[3*k +: 3]);
      cd = int'(i_code[CW*k +: CW]);
      m_done[k] = 1'b0;
      if (i_s_rst) begin
        m_mode[k] = 0; m_led[k] = 1'b0; m_ticks[k] = 0; m_load[k] = 1'b0;
      end else if (md != m_mode[k]) begin
        m_mode[k]  = md;
        m_ticks[k] = 0;
        m_led[k]   = (md >= 1 && md <= 4);
        m_load[k]  = (md == 4);
        m_code[k]  = cd;
      end else if (m_mode[k] == 2 || m_mode[k] == 3) begin
        half = (m_mode[k] == 2) ? 8 : 2;
        if (t) m_ticks[k]++;
        m_led[k] = (((m_ticks[k] / half) % 2) == 0);
      end else if (m_mode[k] == 4) begin
        if (m_load[k]) begin
          m_load[k]  = 1'b0;
          m_ticks[k] = t ? 1 : 0;
          m_led[k]   = code_led(m_code[k], m_ticks[k]);
        end else if (t) begin
          m_ticks[k]++;
          if (m_ticks[k] == 4 * m_code[k] + 8) begin
            m_done[k]  = 1'b1;
            m_load[k]  = 1'b1;
            m_code[k]  = cd;
            m_ticks[k] = 0;
            m_led[k]   = (cd != 0);
          end else begin
            m_led[k] = code_led(m_code[k], m_ticks[k]);
          end
        end
      end else begin
        m_led[k] = (m_mode[k] == 1);
      end
    end
  endtask

  task automatic check();
    logic [CH-1:0] el;
    logic [CH-1:0] ed;
    for (int k = 0; k < CH; k++) begin
      el[k] = m_led[k];
      ed[k] = m_done[k];
    end
    n_vec++;
    assert (o_tick === m_tick) else begin
      n_bad++; $error("FAIL tick @%0t: observed %b expected %b", $time, o_tick, m_tick);
    end
    n_vec++;
    assert (o_led === el) else begin
      n_bad++; $error("FAIL led @%0t: observed %b expected %b", $time, o_led, el);
    end
    n_vec++;
    assert (o_seq_done === ed) else begin
      n_bad++; $error("FAIL seq_done @%0t: observed %b expected %b", $time, o_seq_done, ed);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge i_clk);
      model_edge();
      #1;
      check();
    end
  endtask

  task automatic set_ch(int k, int md, int cd);
    i_mode[3*k +: 3]   = 3'(md);
    i_code[CW*k +: CW] = CW'(cd);
  endtask

  task automatic wait_done(int k, int budget);
    int i;
    i = 0;
    while (o_seq_done[k] !== 1'b1 && i < budget) begin
      step(1);
      i++;
    end
    n_vec++;
    assert (o_seq_done[k] === 1'b1) else begin
      n_bad++; $error("FAIL wait_done%0d: observed no pulse in %0d cycles, expected a pulse", k, budget);
    end
  endtask

  task automatic wait_tick(int budget);
    int i;
    i = 0;
    while (o_tick !== 1'b1 && i < budget) begin
      step(1);
      i++;
    end
    n_vec++;
    assert (o_tick === 1'b1) else begin
      n_bad++; $error("FAIL wait_tick: observed no tick in %0d cycles, expected a tick", budget);
    end
  endtask

  initial begin
    i_s_rst = 1'b1;
    i_mode  = '0;
    i_code  = '0;
    m_since = 0;
    m_tick  = 1'b0;
    for (int k = 0; k < CH; k++) begin
      m_mode[k] = 0; m_ticks[k] = 0; m_code[k] = 0;
      m_load[k] = 1'b0; m_led[k] = 1'b0; m_done[k] = 1'b0;
    end
    step(3);
    i_s_rst = 1'b0;
    step(12);
    // static modes, including a reserved one
    set_ch(0, 1, 0); set_ch(1, 7, 0); step(6);
    set_ch(0, 0, 0); step(6);
    set_ch(0, 1, 0); step(6);
    set_ch(0, 0, 0); step(3);
    // blink fast then slow
    set_ch(2, 3, 0); step(40);
    set_ch(2, 2, 0); step(140);
    // blink code 3, then 1 requested mid-sequence, then 0
    set_ch(3, 4, 3); step(170);
    wait_done(3, 200);
    step(20);
    set_ch(3, 4, 1); step(120);
    set_ch(3, 4, 0); step(100);
    // mode change landing on a tick cycle
    wait_tick(20);
    set_ch(2, 3, 0); step(30);
    // reset pulse in the middle of a flash
    set_ch(3, 0, 0); step(2);
    set_ch(3, 4, 2); step(4);
    i_s_rst = 1'b1; step(1);
    i_s_rst = 1'b0; step(100);
    // random mode/code churn
    for (int r = 0; r < 60; r++) begin
      set_ch($urandom_range(0, CH - 1), $urandom_range(0, 7), $urandom_range(0, 15));
      step($urandom_range(1, 40));
    end
    set_ch(1, 4, $urandom_range(1, 15)); step(300);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/heart_beat_multi.md
Name: heart_beat_multi

Overview:
- Multi-channel successor to the single-LED heart_beat block.
- One shared prescaler generates a slow tick; N independent channels each drive a status LED in a selectable mode: off, on, slow blink, fast blink, or blink-code.
- Sits at board top level. Firmware or status logic drives mode and code inputs to signal link, DMA or error state on front-panel LEDs.

Parameters:
- CHANNELS, 4, number of LED channels (1..16).
- CLK_FREQ_HZ, 125000000, i_clk frequency.
- TICK_HZ, 8, tick rate in normal operation.
- IS_DEBUG, "false", when "true" the prescaler divides by DEBUG_DIV instead of CLK_FREQ_HZ/TICK_HZ.
- DEBUG_DIV, 4, simulation divider (>=2).
- CODE_W, 4, width of the per-channel flash count.

Ports:
- i_clk  in  1  system clock.
- i_s_rst  in  1  synchronous reset, active-high.
- i_mode  in  3*CHANNELS  per-channel mode, channel k at [3k+2:3k].
- i_code  in  CODE_W*CHANNELS  per-channel flash count for CODE mode.
- o_led  out  CHANNELS  registered LED drive.
- o_tick  out  1  one-cycle prescaler tick, registered.
- o_seq_done  out  CHANNELS  one-cycle pulse at the end of each CODE sequence gap.

Behaviour:
- Divider: DIV = (IS_DEBUG=="true") ? DEBUG_DIV : CLK_FREQ_HZ/TICK_HZ.
- Prescaler counts 0..DIV-1 and wraps. o_tick is high for exactly 1 cycle every DIV cycles. The first o_tick occurs DIV cycles after the last cycle with i_s_rst high.
- Reset: prescaler=0, o_tick=0, all o_led=0, all o_seq_done=0. Each channel latched mode=OFF, state=IDLE, phase counter=0.
- Reset asserted mid-operation overrides everything on the next edge, including mid-flash.
- Modes: 0 OFF, 1 ON, 2 BLINK_SLOW, 3 BLINK_FAST, 4 CODE. Values 5..7 are reserved and behave as OFF.
- Mode change:
  - Each channel compares i_mode to its latched mode every cycle.
  - On a difference it latches the new mode and clears its phase counter. o_led reflects the new mode on the next cycle: ON/BLINK/CODE start with LED=1, OFF/reserved give LED=0.
  - A mode change in the same cycle as a tick takes priority; that tick is not counted.
- OFF/ON: o_led constant 0/1, ticks ignored.
- BLINK_SLOW: LED toggles every SLOW_HALF=8 ticks. BLINK_FAST: LED toggles every FAST_HALF=2 ticks.
- Phase alignment: the first phase after a mode change is shortened by the residual prescaler count (0..DIV-1 cycles). All later phases are exactly HALF*DIV cycles.
- CODE FSM states: LOAD, FLASH_ON, FLASH_OFF, GAP.
  - LOAD (1 cycle): latch i_code into cnt. If cnt==0 go to GAP with LED=0, otherwise go to FLASH_ON with LED=1.
  - FLASH_ON lasts FLASH_TICKS=2 ticks, then goes to FLASH_OFF with LED=0 and decrements cnt.
  - FLASH_OFF lasts 2 ticks, then goes to FLASH_ON if cnt!=0, otherwise to GAP.
  - GAP lasts GAP_TICKS=8 ticks with LED=0. On the final gap tick, o_seq_done[k] pulses for 1 cycle and the FSM returns to LOAD.
- i_code changes while in CODE mode are ignored until the next LOAD, so no partial code is ever shown. Max code 2^CODE_W-1 flashes.
- Channels are fully independent and share only the tick.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- heart_beat_pkg holds:
  - the mode enum (OFF, ON, BLINK_SLOW, BLINK_FAST, CODE);
  - the CODE state enum;
  - SLOW_HALF, FAST_HALF, FLASH_TICKS, GAP_TICKS as localparam constants;
  - a function computing DIV.
- Sub-module heart_beat_channel, one per channel, instantiated in a generate loop. It takes i_clk, i_s_rst, i_tick, i_mode, i_code and produces o_led and o_seq_done.
- The prescaler stays in heart_beat_multi.

Test Plan (IS_DEBUG="true", DEBUG_DIV=4, CHANNELS=4):
- Hold i_s_rst for 3 cycles then release -> o_led=0, o_seq_done=0 during reset; first o_tick at cycle 4 after release, then every 4 cycles.
- ch0 mode 0->1->0, ch1 mode 7 -> ch0 o_led high the cycle after each change to 1 and low the cycle after each change to 0; ch1 o_led stays 0.
- ch2 mode=3 held -> after the first toggle, o_led alternates high for 8 cycles and low for 8 cycles. mode=2 -> 32/32.
- ch3 mode=4, code=3 -> 3 pulses of 8 cycles high / 8 cycles low, then 32 cycles low. o_seq_done pulses once per 80-cycle sequence, and the pattern repeats.
- ch3 code changed 3->1 during the second flash -> the current sequence completes with 3 flashes, and the next sequence shows 1 flash. Code=0 -> LED stays 0 while o_seq_done still pulses every 32 cycles.
- i_s_rst asserted for 1 cycle during a CODE FLASH_ON -> o_led=0 next cycle. After release the prescaler restarts, and the sequence restarts with the first flash beginning after LOAD.
